counter_mod_updown: RTL and testbench
=====================================

// Module: counter_mod_updown
// PURPOSE
//   Parametrised up/down modulo counter with clock enable, parallel load,
//   optional saturation and a registered carry/borrow pulse.
//   Generalises the fixed 4-bit free-running incrementer: width, modulus, init
//   value and wrap/saturate mode are set per instance.
//   Sits in timing/sequencing datapaths as a period generator, address
//   pointer or event counter.
// PARAMETERS
//   WIDTH    4                 counter width in bits, >= 1
//   MAX      (1<<WIDTH)-1      terminal value; count range is 0..MAX; MAX < 2**WIDTH
//   INIT     0                 value loaded on RESET; INIT <= MAX
//   SATURATE 0                 0 = wrap at range ends, 1 = hold at range ends
// PORTS
//   CLK    in   1      clock; all state updates on rising edge
//   RESET  in   1      synchronous, active-high reset
//   CE     in   1      count enable
//   UP     in   1      direction: 1 = increment, 0 = decrement (sampled when CE=1)
//   LOAD   in   1      parallel load strobe
//   D      in   WIDTH  load value
//   O      out  WIDTH  current count (registered)
//   COUT   out  1      carry/borrow/saturate event pulse (registered)
//   ZERO   out  1      combinational, 1 when O == 0
// BEHAVIOUR
//   - Priority per edge: RESET > LOAD > CE. With none of them asserted, O holds
//     and COUT <= 0.
//   - RESET: O <= INIT, COUT <= 0. RESET applied mid-count discards any
//     pending event: no COUT in the following cycle.
//   - LOAD: O <= min(D, MAX), COUT <= 0. CE and UP are ignored in that cycle.
//   - CE=1, UP=1:
//       O < MAX               -> O <= O+1, COUT <= 0
//       O == MAX, SATURATE=0  -> O <= 0,   COUT <= 1
//       O == MAX, SATURATE=1  -> O holds MAX, COUT <= 1
//   - CE=1, UP=0:
//       O > 0                 -> O <= O-1, COUT <= 0
//       O == 0, SATURATE=0    -> O <= MAX, COUT <= 1
//       O == 0, SATURATE=1    -> O holds 0, COUT <= 1
//   - Timing: COUT is high for exactly the one cycle after the wrapping or
//     saturating edge. It is re-asserted every cycle while saturated with CE=1.
//   - Arithmetic: next-value and compare logic is computed in WIDTH+1 bits,
//     so MAX = 2**WIDTH-1 does not overflow. O never leaves 0..MAX.
//   - Latency: 1 cycle from CE/LOAD to O. ZERO follows O with no added delay.
//   - Illegal parameters (MAX >= 2**WIDTH, INIT > MAX): elaboration-time
//     error, not runtime behaviour.
// TESTING
//   1 WIDTH=4 defaults: RESET then CE=1,UP=1 for 17 cycles -> O 0..15,0,1;
//     COUT=1 only in the cycle O first reads 0 after 15.
//   2 WIDTH=4, MAX=9: UP=0 from reset -> O 0,9,8,...; COUT=1 in the cycle
//     O first reads 9; ZERO=1 only when O=0.
//   3 WIDTH=8, MAX=200, SATURATE=1: LOAD D=198, then CE=1,UP=1 x4 ->
//     O 199,200,200,200; COUT=1 for each of the last two cycles.
//   4 LOAD D=15 with MAX=9 -> O=9, COUT=0; same cycle CE=1,UP=1 has no effect.
//   5 RESET, LOAD and CE asserted together, INIT=5, D=3 -> O=5, COUT=0;
//     RESET on the wrap edge -> O=INIT and no COUT pulse.
//   6 CE=0 for 10 cycles with UP toggling -> O and COUT unchanged (COUT=0).

Source files
------------

// File: rtl/counter_mod_updown.sv
// Parametrised up/down modulo counter with clock enable, parallel load,
// optional saturation at the range ends and a registered carry/borrow pulse.
module counter_mod_updown #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX      = (1 << WIDTH) - 1,
  parameter int unsigned INIT     = 0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             ZERO
);

  typedef logic [WIDTH:0]   ext_t;
  typedef logic [WIDTH-1:0] cnt_t;

  localparam ext_t MAX_X  = ext_t'(MAX);
  localparam cnt_t MAX_V  = cnt_t'(MAX);
  localparam cnt_t INIT_V = cnt_t'(INIT);

  if (WIDTH < 1 || longint'(MAX) >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("counter_mod_updown: MAX must lie in 0..2**WIDTH-1");
  end
  if (INIT > MAX) begin : g_bad_init
    $error("counter_mod_updown: INIT must not exceed MAX");
  end

  ext_t o_x;
  ext_t d_x;
  cnt_t nxt_o;
  logic nxt_cout;

  // Range compares use one extra bit so MAX = 2**WIDTH-1 never aliases.
  assign o_x = {1'b0, O};
  assign d_x = {1'b0, D};

  always_comb begin
    nxt_o    = O;
    nxt_cout = 1'b0;
    if (LOAD) begin
      nxt_o = (d_x > MAX_X) ? MAX_V : D;
    end else if (CE) begin
      if (UP) begin
        if (o_x >= MAX_X) begin
          nxt_cout = 1'b1;
          nxt_o    = SATURATE ? MAX_V : '0;
        end else begin
          nxt_o = O + cnt_t'(1);
        end
      end else begin
        if (o_x == '0) begin
          nxt_cout = 1'b1;
          nxt_o    = SATURATE ? cnt_t'(0) : MAX_V;
        end else begin
          nxt_o = O - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      O    <= INIT_V;
      COUT <= 1'b0;
    end else begin
      O    <= nxt_o;
      COUT <= nxt_cout;
    end
  end

  assign ZERO = (O == '0);

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench for counter_mod_updown: four differently parametrised instances share
// one stimulus stream and are checked against an integer reference model.
module tb_counter_mod_updown;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] d8 = '0;
  logic [3:0] d4;

  logic [3:0] o_a, o_b, o_d;
  logic [7:0] o_c;
  logic       cout_a, cout_b, cout_c, cout_d;
  logic       zero_a, zero_b, zero_c, zero_d;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state per instance: a=default, b=MAX 9, c=8-bit sat, d=INIT 5
  int mx  [4] = '{15, 9, 200, 9};
  int ini [4] = '{0, 0, 0, 5};
  bit sat [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int m_o [4];
  bit m_c [4];

  assign d4 = d8[3:0];

  always #5 clk = ~clk;

  counter_mod_updown #(.WIDTH(4)) u_a (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .D(d4),
    .O(o_a), .COUT(cout_a), .ZERO(zero_a));

  counter_mod_updown #(.WIDTH(4), .MAX(9)) u_b (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .D(d4),
    .O(o_b), .COUT(cout_b), .ZERO(zero_b));

  counter_mod_updown #(.WIDTH(8), .MAX(200), .SATURATE(1'b1)) u_c (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .D(d8),
    .O(o_c), .COUT(cout_c), .ZERO(zero_c));

  counter_mod_updown #(.WIDTH(4), .MAX(9), .INIT(5)) u_d (
    .CLK(clk), .RESET(rst), .CE(ce), .UP(up), .LOAD(load), .D(d4),
    .O(o_d), .COUT(cout_d), .ZERO(zero_d));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next count from the behavioural rules, plain integer arithmetic.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int dv;
      dv = (i == 2) ? int'(d8) : int'(d8) % 16;
      if (rst) begin
        m_o[i] = ini[i];
        m_c[i] = 1'b0;
      end else if (load) begin
        m_o[i] = (dv > mx[i]) ? mx[i] : dv;
        m_c[i] = 1'b0;
      end else if (ce && up) begin
        m_c[i] = (m_o[i] == mx[i]);
        if (m_o[i] < mx[i]) m_o[i] = m_o[i] + 1;
        else if (!sat[i]) m_o[i] = 0;
      end else if (ce) begin
        m_c[i] = (m_o[i] == 0);
        if (m_o[i] > 0) m_o[i] = m_o[i] - 1;
        else if (!sat[i]) m_o[i] = mx[i];
      end else begin
        m_c[i] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("a.O", {4'b0, o_a}, 8'(m_o[0]));
    chk("a.COUT", {7'b0, cout_a}, {7'b0, m_c[0]});
    chk("a.ZERO", {7'b0, zero_a}, {7'b0, m_o[0] == 0});
    chk("b.O", {4'b0, o_b}, 8'(m_o[1]));
    chk("b.COUT", {7'b0, cout_b}, {7'b0, m_c[1]});
    chk("b.ZERO", {7'b0, zero_b}, {7'b0, m_o[1] == 0});
    chk("c.O", o_c, 8'(m_o[2]));
    chk("c.COUT", {7'b0, cout_c}, {7'b0, m_c[2]});
    chk("c.ZERO", {7'b0, zero_c}, {7'b0, m_o[2] == 0});
    chk("d.O", {4'b0, o_d}, 8'(m_o[3]));
    chk("d.COUT", {7'b0, cout_d}, {7'b0, m_c[3]});
    chk("d.ZERO", {7'b0, zero_d}, {7'b0, m_o[3] == 0});
  endtask

  task automatic cycle(input logic r, input logic l, input logic c,
                       input logic u, input logic [7:0] dv);
    rst = r; load = l; ce = c; up = u; d8 = dv;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_o[i] = 0;
      m_c[i] = 1'b0;
    end
    #2;
    // reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset.d.O", {4'b0, o_d}, 8'd5);

    // full-range up count with wrap
    for (int k = 0; k < 17; k++) cycle(0, 0, 1, 1, 0);
    chk("wrap.a.O", {4'b0, o_a}, 8'd1);

    // down count from reset, borrow to MAX
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("borrow.b.O", {4'b0, o_b}, 8'd9);
    chk("borrow.b.COUT", {7'b0, cout_b}, 8'd1);
    for (int k = 0; k < 11; k++) cycle(0, 0, 1, 0, 0);

    // saturation at MAX=200
    cycle(0, 1, 0, 0, 8'd198);
    for (int k = 0; k < 4; k++) cycle(0, 0, 1, 1, 0);
    chk("sat.c.O", o_c, 8'd200);
    chk("sat.c.COUT", {7'b0, cout_c}, 8'd1);

    // load clamps to MAX, CE ignored
    cycle(0, 1, 1, 1, 8'd15);
    chk("clamp.b.O", {4'b0, o_b}, 8'd9);
    chk("clamp.b.COUT", {7'b0, cout_b}, 8'd0);

    // reset beats load and CE; reset on the wrap edge suppresses COUT
    cycle(1, 1, 1, 1, 8'd3);
    cycle(0, 1, 0, 0, 8'd9);
    cycle(1, 0, 1, 1, 0);
    chk("rstwrap.d.O", {4'b0, o_d}, 8'd5);
    chk("rstwrap.d.COUT", {7'b0, cout_d}, 8'd0);

    // hold with CE low and UP toggling
    cycle(0, 1, 0, 0, 8'd7);
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, k[0], 0);

    // saturation at zero re-asserts COUT each cycle
    cycle(0, 1, 0, 0, 8'd0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0);

    // randomised traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
